// File: rtl/hps_reset_pkg.sv
// Shared types and default timing for the HPS reset-request sequencer.
package hps_reset_pkg;

    localparam logic [1:0] ST_POR     = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_ASSERT  = 2'd2;
    localparam logic [1:0] ST_HOLDOFF = 2'd3;

    typedef enum logic [1:0] {
        REQ_COLD,
        REQ_WARM,
        REQ_DEBUG
    } req_type_t;

    // Defaults assume a 50 MHz clock.
    localparam int DEF_DEBOUNCE_CYCLES   = 1000000;
    localparam int DEF_PULSE_CYCLES      = 64;
    localparam int DEF_HOLDOFF_CYCLES    = 4096;
    localparam int DEF_LONG_PRESS_CYCLES = 100000000;
    localparam int DEF_POR_COLD          = 0;
    localparam int DEF_POR_CYCLES        = 1024;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hps_reset_req_ctrl_key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, and a
// one-cycle pulse on each accepted press (debounced falling edge).
module key_debounce
    import hps_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             fall_reg;

    // Any sample agreeing with the accepted level restarts the count, so only
    // an uninterrupted run of the opposite level is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            cnt_reg   <= '0;
            level_reg <= 1'b1;
            fall_reg  <= 1'b0;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
            fall_reg  <= 1'b0;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_reg <= sync2_reg;
                fall_reg  <= ~sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/hps_reset_req_ctrl.sv
// Fabric-side sequencer producing clean, prioritised, spaced active-low
// cold/warm/debug reset-request pulses for the HPS f2h reset inputs.
module hps_reset_req_ctrl
    import hps_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES      = DEF_PULSE_CYCLES,
    parameter int HOLDOFF_CYCLES    = DEF_HOLDOFF_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int POR_COLD          = DEF_POR_COLD,
    parameter int POR_CYCLES        = DEF_POR_CYCLES
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       key_warm_n,
    input  logic       key_debug_n,
    input  logic       sw_req_cold,
    input  logic       sw_req_warm,
    output logic       hps_cold_reset_req_n,
    output logic       hps_warm_reset_req_n,
    output logic       hps_debug_reset_req_n,
    output logic       busy,
    output logic [7:0] req_count
);

    localparam int TMR_MAX = max3(POR_CYCLES, PULSE_CYCLES, HOLDOFF_CYCLES);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int LP_W    = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [1:0] ST_START = (POR_COLD != 0) ? ST_POR : ST_IDLE;

    logic warm_level, warm_fall, debug_fall, debug_level_unused;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_warm (
        .clk(clk_clk), .rst(reset_reset), .key_n(key_warm_n),
        .level(warm_level), .fall(warm_fall)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_debug (
        .clk(clk_clk), .rst(reset_reset), .key_n(key_debug_n),
        .level(debug_level_unused), .fall(debug_fall)
    );

    // Long press escalates once per press; releasing the key re-arms it.
    logic [LP_W-1:0] lp_cnt_reg;
    logic            lp_done_reg;
    logic            lp_hit;

    assign lp_hit = ~warm_level & ~lp_done_reg &
                    (lp_cnt_reg == LP_W'(LONG_PRESS_CYCLES - 1));

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            lp_cnt_reg  <= '0;
            lp_done_reg <= 1'b0;
        end else if (warm_level) begin
            lp_cnt_reg  <= '0;
            lp_done_reg <= 1'b0;
        end else if (lp_hit) begin
            lp_done_reg <= 1'b1;
        end else if (!lp_done_reg) begin
            lp_cnt_reg <= lp_cnt_reg + 1'b1;
        end
    end

    logic [1:0]       state_reg, state_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic [7:0]       count_reg, count_next;
    logic             cold_n_reg, cold_n_next;
    logic             warm_n_reg, warm_n_next;
    logic             debug_n_reg, debug_n_next;
    logic             pend_cold_reg, pend_warm_reg, pend_debug_reg;
    logic             clr_cold, clr_warm, clr_debug, por_done;
    req_type_t        sel_type;

    always_comb begin
        if (pend_cold_reg)      sel_type = REQ_COLD;
        else if (pend_warm_reg) sel_type = REQ_WARM;
        else                    sel_type = REQ_DEBUG;
    end

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        count_next   = count_reg;
        cold_n_next  = cold_n_reg;
        warm_n_next  = warm_n_reg;
        debug_n_next = debug_n_reg;
        clr_cold     = 1'b0;
        clr_warm     = 1'b0;
        clr_debug    = 1'b0;
        por_done     = 1'b0;
        case (state_reg)
            ST_POR: begin
                if (timer_reg == TMR_W'(POR_CYCLES - 1)) begin
                    por_done   = 1'b1;
                    state_next = ST_IDLE;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            ST_IDLE: begin
                if (pend_cold_reg | pend_warm_reg | pend_debug_reg) begin
                    // A cold reset subsumes any lesser request already queued.
                    clr_cold     = (sel_type == REQ_COLD);
                    clr_warm     = (sel_type == REQ_COLD) || (sel_type == REQ_WARM);
                    clr_debug    = (sel_type == REQ_COLD) || (sel_type == REQ_DEBUG);
                    cold_n_next  = (sel_type != REQ_COLD);
                    warm_n_next  = (sel_type != REQ_WARM);
                    debug_n_next = (sel_type != REQ_DEBUG);
                    count_next   = count_reg + 1'b1;
                    state_next   = ST_ASSERT;
                    timer_next   = '0;
                end
            end
            ST_ASSERT: begin
                if (timer_reg == TMR_W'(PULSE_CYCLES - 1)) begin
                    cold_n_next  = 1'b1;
                    warm_n_next  = 1'b1;
                    debug_n_next = 1'b1;
                    state_next   = ST_HOLDOFF;
                    timer_next   = '0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: begin
                if (timer_reg == TMR_W'(HOLDOFF_CYCLES - 1)) begin
                    state_next = ST_IDLE;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
        endcase
    end

    // New events are OR-ed in after the clear so a same-cycle request survives.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_reg      <= ST_START;
            timer_reg      <= '0;
            count_reg      <= '0;
            cold_n_reg     <= 1'b1;
            warm_n_reg     <= 1'b1;
            debug_n_reg    <= 1'b1;
            pend_cold_reg  <= 1'b0;
            pend_warm_reg  <= 1'b0;
            pend_debug_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            count_reg      <= count_next;
            cold_n_reg     <= cold_n_next;
            warm_n_reg     <= warm_n_next;
            debug_n_reg    <= debug_n_next;
            pend_cold_reg  <= (pend_cold_reg & ~clr_cold) | sw_req_cold | lp_hit | por_done;
            pend_warm_reg  <= (pend_warm_reg & ~clr_warm) | sw_req_warm | warm_fall;
            pend_debug_reg <= (pend_debug_reg & ~clr_debug) | debug_fall;
        end
    end

    assign hps_cold_reset_req_n  = cold_n_reg;
    assign hps_warm_reset_req_n  = warm_n_reg;
    assign hps_debug_reset_req_n = debug_n_reg;
    assign busy                  = (state_reg != ST_IDLE);
    assign req_count             = count_reg;

endmodule

// File: tb/tb_hps_reset_req_ctrl.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge monitor
// measures every request pulse and compares it against the queue.
module tb_hps_reset_req_ctrl;

    localparam int T_COLD  = 0;
    localparam int T_WARM  = 1;
    localparam int T_DEBUG = 2;
    localparam int PULSE   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_warm_n = 1'b1;
    logic       key_debug_n = 1'b1;
    logic       sw_req_cold = 1'b0;
    logic       sw_req_warm = 1'b0;
    logic       cold_n, warm_n, debug_n, busy;
    logic [7:0] req_count;

    always #5 clk = ~clk;

    hps_reset_req_ctrl #(
        .DEBOUNCE_CYCLES(8), .PULSE_CYCLES(PULSE), .HOLDOFF_CYCLES(10),
        .LONG_PRESS_CYCLES(50), .POR_COLD(1), .POR_CYCLES(16)
    ) dut (
        .clk_clk(clk), .reset_reset(rst),
        .key_warm_n(key_warm_n), .key_debug_n(key_debug_n),
        .sw_req_cold(sw_req_cold), .sw_req_warm(sw_req_warm),
        .hps_cold_reset_req_n(cold_n), .hps_warm_reset_req_n(warm_n),
        .hps_debug_reset_req_n(debug_n), .busy(busy), .req_count(req_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_count = 0;

    typedef struct {
        int typ;
        int cnt;
        int lo;
        int hi;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_pulse(input int typ, input int lo, input int hi);
        exp_t e;
        exp_count = (exp_count + 1) % 256;
        e.typ = typ;
        e.cnt = exp_count;
        e.lo  = lo;
        e.hi  = hi;
        sb_q.push_back(e);
    endtask

    function automatic bit req_n_of(input int t);
        case (t)
            T_COLD:  return cold_n;
            T_WARM:  return warm_n;
            default: return debug_n;
        endcase
    endfunction

    task automatic wait_req(input int t, input bit val);
        int n = 0;
        while (req_n_of(t) != val && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_req_in_time", (req_n_of(t) == val) ? 1 : 0, 1);
    endtask

    task automatic wait_idle();
        int stable = 0;
        for (int i = 0; i < 600 && stable < 3; i++) begin
            @(negedge clk);
            stable = busy ? 0 : stable + 1;
        end
        check("idle_in_time", (stable >= 3) ? 1 : 0, 1);
    endtask

    // Cycle index since reset release: the period after edge k is cycle k+1.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    bit       in_pulse = 1'b0;
    int       cur_typ, cur_cnt, cur_start, cur_width;
    logic [2:0] low_vec;
    exp_t     mon_e;

    always @(negedge clk) begin
        low_vec = {~debug_n, ~warm_n, ~cold_n};
        if (rst) begin
            in_pulse = 1'b0;
        end else if (!in_pulse) begin
            if (low_vec != 3'b000) begin
                check("onehot_start", $countones(low_vec), 1);
                in_pulse  = 1'b1;
                cur_typ   = low_vec[0] ? T_COLD : (low_vec[1] ? T_WARM : T_DEBUG);
                cur_cnt   = int'(req_count);
                cur_start = cyc + 1;
                cur_width = 1;
            end
        end else if (low_vec == 3'b000) begin
            in_pulse = 1'b0;
            $display("pulse type=%0d start_cycle=%0d width=%0d req_count=%0d",
                     cur_typ, cur_start, cur_width, cur_cnt);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: type %0d at cycle %0d, expected none",
                         cur_typ, cur_start);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_type", cur_typ, mon_e.typ);
                check("pulse_width", cur_width, PULSE);
                check("pulse_req_count", cur_cnt, mon_e.cnt);
                checks++;
                if (cur_start < mon_e.lo || cur_start > mon_e.hi) begin
                    errors++;
                    $display("FAIL pulse_start: got cycle %0d, expected %0d..%0d",
                             cur_start, mon_e.lo, mon_e.hi);
                end
            end
        end else begin
            cur_width++;
            check("onehot_hold", int'(low_vec), 1 << cur_typ);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    int c, s, n;

    initial begin
        // Reset state and power-on cold request
        expect_pulse(T_COLD, 18, 18);
        repeat (3) @(negedge clk);
        check("rst_cold_n", int'(cold_n), 1);
        check("rst_warm_n", int'(warm_n), 1);
        check("rst_debug_n", int'(debug_n), 1);
        check("rst_busy", int'(busy), 1);
        check("rst_req_count", int'(req_count), 0);
        rst = 1'b0;
        wait_req(T_COLD, 1'b0);
        wait_req(T_COLD, 1'b1);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("busy_fall_delay", n, 10);
        check("por_req_count", int'(req_count), 1);

        // Bouncing warm key, then a clean press
        for (int k = 0; k < 10; k++) begin
            key_warm_n = (k % 2 == 0) ? 1'b0 : 1'b1;
            repeat (3) @(negedge clk);
        end
        key_warm_n = 1'b0;
        c = cyc;
        expect_pulse(T_WARM, c + 1, c + 20);
        repeat (20) @(negedge clk);
        key_warm_n = 1'b1;
        repeat (15) @(negedge clk);
        wait_idle();

        // Simultaneous cold and warm software requests
        c = cyc;
        sw_req_warm = 1'b1;
        sw_req_cold = 1'b1;
        expect_pulse(T_COLD, c + 3, c + 3);
        @(negedge clk);
        sw_req_warm = 1'b0;
        sw_req_cold = 1'b0;
        wait_idle();
        check("count_after_simultaneous", int'(req_count), exp_count);

        // Warm requests coalesce while a debug pulse is asserted
        key_debug_n = 1'b0;
        c = cyc;
        expect_pulse(T_DEBUG, c + 1, c + 20);
        wait_req(T_DEBUG, 1'b0);
        s = cyc;
        expect_pulse(T_WARM, s + 16, s + 16);
        for (int k = 0; k < 3; k++) begin
            sw_req_warm = 1'b1;
            @(negedge clk);
            sw_req_warm = 1'b0;
        end
        key_debug_n = 1'b1;
        wait_idle();
        check("count_after_coalesce", int'(req_count), exp_count);

        // Long press escalation, twice
        for (int r = 0; r < 2; r++) begin
            key_warm_n = 1'b0;
            c = cyc;
            expect_pulse(T_WARM, c + 1, c + 20);
            expect_pulse(T_COLD, c + 50, c + 80);
            repeat (70) @(negedge clk);
            key_warm_n = 1'b1;
            repeat (20) @(negedge clk);
            wait_idle();
        end
        check("count_after_long_press", int'(req_count), exp_count);

        // Reset during the second cycle of a warm pulse
        sw_req_warm = 1'b1;
        @(negedge clk);
        sw_req_warm = 1'b0;
        wait_req(T_WARM, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_warm_n", int'(warm_n), 1);
        check("async_rst_req_count", int'(req_count), 0);
        check("async_rst_busy", int'(busy), 1);
        exp_count = 0;
        repeat (3) @(negedge clk);
        expect_pulse(T_COLD, 18, 18);
        rst = 1'b0;
        wait_idle();
        check("count_after_rst", int'(req_count), 1);

        // Counter wrap: 255 more requests brings the total to 256
        for (int k = 0; k < 255; k++) begin
            c = cyc;
            sw_req_warm = 1'b1;
            expect_pulse(T_WARM, c + 3, c + 3);
            @(negedge clk);
            sw_req_warm = 1'b0;
            wait_idle();
        end
        check("count_wrap", int'(req_count), 0);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
